game_controller: RTL and testbench

GAME_CONTROLLER -- requirements
Module: game_controller

---
 rtl/game2048_pkg.sv | 68 ++++++
 rtl/game2048_move.sv | 57 +++++
 rtl/lfsr16.sv | 25 ++
 rtl/game_controller.sv | 204 ++++++++++++++++++++
 tb/tb_game_controller.sv | 379 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/game2048_pkg.sv
// Shared types, constants and the line-merge helper for the 2048 game controller.
package game2048_pkg;

   localparam int unsigned SCORE_W = 20;

   typedef logic [11:0]        tile_t;
   typedef tile_t [3:0]        line_t;   // index 0 is the edge tiles slide toward
   typedef tile_t [3:0][3:0]   board_t;  // [row][col], cell = row*4+col
   typedef logic [SCORE_W-1:0] score_t;

   typedef enum logic [2:0] {
      S_INIT,
      S_SPAWN,
      S_IDLE,
      S_MOVE,
      S_CHECK,
      S_OVER
   } state_t;

   localparam logic [3:0] DIR_LEFT  = 4'b0001;
   localparam logic [3:0] DIR_UP    = 4'b0010;
   localparam logic [3:0] DIR_RIGHT = 4'b0100;
   localparam logic [3:0] DIR_DOWN  = 4'b1000;

   typedef struct packed {
      line_t  line;
      score_t score;
   } merge_res_t;

   function automatic logic is_one_hot(input logic [3:0] d);
      return (d != 4'b0000) && ((d & (d - 4'd1)) == 4'b0000);
   endfunction

   // Slide one line toward index 0; each tile takes part in at most one merge.
   function automatic merge_res_t merge_line(input line_t in_line);
      tile_t [4:0] comp;  // compacted tiles; slot 4 stays empty as a sentinel
      logic [2:0]  n;
      logic        skip;
      merge_res_t  res;
      comp = '0;
      n    = '0;
      for (int k = 0; k < 4; k++) begin
         if (in_line[k] != '0) begin
            comp[n] = in_line[k];
            n       = n + 3'd1;
         end
      end
      res  = '0;
      n    = '0;
      skip = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (skip) begin
            skip = 1'b0;
         end else if (comp[k] != '0) begin
            if (comp[k] == comp[k+1]) begin
               res.line[n[1:0]] = {comp[k][10:0], 1'b0};
               res.score        = res.score + score_t'({comp[k], 1'b0});
               skip             = 1'b1;
            end else begin
               res.line[n[1:0]] = comp[k];
            end
            n = n + 3'd1;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/game2048_move.sv
// Combinational move/merge datapath: applies one one-hot direction to a whole board.
module game2048_move
   import game2048_pkg::*;
(
   input  board_t     board,
   input  logic [3:0] dir,
   output board_t     result,
   output score_t     score_update
);

   line_t [3:0]      line_in;
   merge_res_t [3:0] merged;

   // Gather each row/column so that index 0 is the edge the tiles slide toward.
   always_comb begin
      line_in = '0;
      for (int i = 0; i < 4; i++) begin
         for (int k = 0; k < 4; k++) begin
            case (dir)
               DIR_LEFT:  line_in[i][k] = board[i][k];
               DIR_RIGHT: line_in[i][k] = board[i][3-k];
               DIR_UP:    line_in[i][k] = board[k][i];
               DIR_DOWN:  line_in[i][k] = board[3-k][i];
               default:   line_in[i][k] = board[i][k];
            endcase
         end
      end
   end

   // Merge every line independently.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         merged[i] = merge_line(line_in[i]);
      end
   end

   // Scatter merged lines back to board coordinates and total the merge score.
   always_comb begin
      result       = board;
      score_update = '0;
      if (is_one_hot(dir)) begin
         for (int i = 0; i < 4; i++) begin
            score_update = score_update + merged[i].score;
            for (int k = 0; k < 4; k++) begin
               case (dir)
                  DIR_LEFT:  result[i][k]   = merged[i].line[k];
                  DIR_RIGHT: result[i][3-k] = merged[i].line[k];
                  DIR_UP:    result[k][i]   = merged[i].line[k];
                  DIR_DOWN:  result[3-k][i] = merged[i].line[k];
                  default:   ;
               endcase
            end
         end
      end
   end

endmodule

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11, with synchronous seed load.
module lfsr16 (
   input  logic        clk,
   input  logic        load,
   input  logic        step,
   input  logic [15:0] seed,
   output logic [15:0] value
);

   logic [15:0] value_q;
   logic        feedback;

   assign feedback = value_q[0] ^ value_q[2] ^ value_q[3] ^ value_q[5];
   assign value    = value_q;

   // Load has priority so a seed always wins over a step in the same cycle.
   always_ff @(posedge clk) begin
      if (load) begin
         value_q <= seed;
      end else if (step) begin
         value_q <= {feedback, value_q[15:1]};
      end
   end

endmodule

// File: rtl/game_controller.sv
// 2048 game controller: move handshake, random tile spawn, win and game-over detection.
module game_controller
   import game2048_pkg::*;
#(
   parameter tile_t       WIN_TILE  = 12'h800,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               dir_valid,
   input  logic [3:0]         dir,
   output logic               dir_ready,
   output board_t             board,
   output logic [SCORE_W-1:0] score,
   output logic               busy,
   output logic               game_won,
   output logic               game_over
);

   state_t       state_q, state_d;
   board_t       board_q, board_d;
   logic         board_we;
   score_t       score_q, score_d;
   logic         score_we;
   logic         won_q, won_d;
   logic         changed_q, changed_d;
   logic [1:0]   spawn_cnt_q, spawn_cnt_d;
   logic [3:0]   idx_q, idx_d;
   logic [3:0]   probe_q, probe_d;
   logic [3:0]   dir_q, dir_d;

   logic [15:0]  lfsr_value;
   board_t       move_result;
   score_t       move_score;
   logic         move_changed;
   logic [SCORE_W:0] score_sum;
   score_t       score_sat;
   tile_t        spawn_cell;
   logic         has_empty, has_pair, any_win;
   logic         unused_bits;

   lfsr16 u_lfsr (
      .clk   (clk),
      .load  (rst | start),
      .step  (1'b1),
      .seed  (LFSR_SEED),
      .value (lfsr_value)
   );

   game2048_move u_move (
      .board        (board_q),
      .dir          (dir_q),
      .result       (move_result),
      .score_update (move_score)
   );

   assign move_changed = (move_result != board_q);
   assign score_sum    = {1'b0, score_q} + {1'b0, move_score};
   assign score_sat    = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
   assign spawn_cell   = board_q[idx_q[3:2]][idx_q[1:0]];
   // Upper LFSR bits and the changed flag have no consumer beyond the FSM decision.
   assign unused_bits  = ^{lfsr_value[15:8], changed_q};

   assign dir_ready = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE) && (state_q != S_OVER);
   assign game_over = (state_q == S_OVER);
   assign board     = board_q;
   assign score     = score_q;
   assign game_won  = won_q;

   // Board-wide flags evaluated in S_CHECK.
   always_comb begin
      has_empty = 1'b0;
      has_pair  = 1'b0;
      any_win   = 1'b0;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (board_q[r][c] == '0)       has_empty = 1'b1;
            if (board_q[r][c] >= WIN_TILE) any_win   = 1'b1;
         end
         for (int c = 0; c < 3; c++) begin
            if (board_q[r][c] == board_q[r][c+1]) has_pair = 1'b1;
            if (board_q[c][r] == board_q[c+1][r]) has_pair = 1'b1;
         end
      end
   end

   // Next-state logic; start overrides whatever the FSM was doing.
   always_comb begin
      state_d     = state_q;
      board_d     = board_q;
      board_we    = 1'b0;
      score_d     = score_q;
      score_we    = 1'b0;
      won_d       = won_q;
      changed_d   = changed_q;
      spawn_cnt_d = spawn_cnt_q;
      idx_d       = idx_q;
      probe_d     = probe_q;
      dir_d       = dir_q;

      if (start) begin
         state_d     = S_INIT;
         board_d     = '0;
         board_we    = 1'b1;
         score_d     = '0;
         score_we    = 1'b1;
         won_d       = 1'b0;
         changed_d   = 1'b0;
         spawn_cnt_d = 2'd2;
      end else begin
         unique case (state_q)
            S_INIT: begin
               board_d     = '0;
               board_we    = 1'b1;
               score_d     = '0;
               score_we    = 1'b1;
               won_d       = 1'b0;
               changed_d   = 1'b0;
               spawn_cnt_d = 2'd2;
               idx_d       = lfsr_value[3:0];
               probe_d     = '0;
               state_d     = S_SPAWN;
            end
            S_SPAWN: begin
               if (spawn_cell == '0) begin
                  board_d[idx_q[3:2]][idx_q[1:0]] =
                     (lfsr_value[7:4] == 4'd0) ? tile_t'(12'h004) : tile_t'(12'h002);
                  board_we = 1'b1;
                  if (spawn_cnt_q <= 2'd1) begin
                     spawn_cnt_d = 2'd0;
                     state_d     = S_CHECK;
                  end else begin
                     spawn_cnt_d = spawn_cnt_q - 2'd1;
                     idx_d       = lfsr_value[3:0];
                     probe_d     = '0;
                  end
               end else if (probe_q == 4'd15) begin
                  // Whole board probed without a free cell.
                  spawn_cnt_d = 2'd0;
                  state_d     = S_CHECK;
               end else begin
                  idx_d   = idx_q + 4'd1;
                  probe_d = probe_q + 4'd1;
               end
            end
            S_IDLE: begin
               if (dir_valid) begin
                  dir_d = dir;
                  if (is_one_hot(dir)) state_d = S_MOVE;
               end
            end
            S_MOVE: begin
               board_d   = move_result;
               board_we  = 1'b1;
               score_d   = score_sat;
               score_we  = 1'b1;
               changed_d = move_changed;
               if (move_changed) begin
                  spawn_cnt_d = 2'd1;
                  idx_d       = lfsr_value[3:0];
                  probe_d     = '0;
                  state_d     = S_SPAWN;
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_CHECK: begin
               if (any_win) won_d = 1'b1;
               state_d = (!has_empty && !has_pair) ? S_OVER : S_IDLE;
            end
            S_OVER: state_d = S_OVER;
            default: state_d = S_INIT;
         endcase
      end
   end

   // State registers; board and score only load when the FSM updates them.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_INIT;
         board_q     <= '0;
         score_q     <= '0;
         won_q       <= 1'b0;
         changed_q   <= 1'b0;
         spawn_cnt_q <= 2'd2;
         idx_q       <= '0;
         probe_q     <= '0;
         dir_q       <= '0;
      end else begin
         state_q     <= state_d;
         if (board_we) board_q <= board_d;
         if (score_we) score_q <= score_d;
         won_q       <= won_d;
         changed_q   <= changed_d;
         spawn_cnt_q <= spawn_cnt_d;
         idx_q       <= idx_d;
         probe_q     <= probe_d;
         dir_q       <= dir_d;
      end
   end

endmodule

// File: tb/tb_game_controller.sv
// Directed self-checking bench for game_controller.
module tb_game_controller;
   import game2048_pkg::*;

   logic               clk = 1'b0;
   logic               rst;
   logic               start;
   logic               dir_valid;
   logic [3:0]         dir;
   logic               dir_ready;
   board_t             board;
   logic [SCORE_W-1:0] score;
   logic               busy;
   logic               game_won;
   logic               game_over;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   game_controller #(
      .WIN_TILE  (12'h800),
      .LFSR_SEED (16'hACE1)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .dir_valid (dir_valid),
      .dir       (dir),
      .dir_ready (dir_ready),
      .board     (board),
      .score     (score),
      .busy      (busy),
      .game_won  (game_won),
      .game_over (game_over)
   );

   function automatic line_t mk_row(input tile_t a, input tile_t b, input tile_t c,
                                    input tile_t d);
      line_t l;
      l[0] = a;
      l[1] = b;
      l[2] = c;
      l[3] = d;
      return l;
   endfunction

   // Place a board and score directly into the idle controller.
   task automatic preload(input board_t b, input score_t s);
      dut.board_q = b;
      dut.score_q = s;
   endtask

   task automatic wait_ready(input int max, output int n, output bit ok);
      n  = 0;
      ok = 1'b0;
      while (n < max && !ok) begin
         @(negedge clk);
         n++;
         if (dir_ready === 1'b1) ok = 1'b1;
      end
   endtask

   // Caller sits at a negedge with dir_ready high; returns one cycle after the accept.
   task automatic do_move(input logic [3:0] d);
      dir_valid = 1'b1;
      dir       = d;
      @(negedge clk);
      dir_valid = 1'b0;
      dir       = 4'b0000;
   endtask

   task automatic test_reset();
      int n;
      bit ok;
      int tiles;
      bit vals_ok;
      rst       = 1'b1;
      start     = 1'b0;
      dir_valid = 1'b0;
      dir       = 4'b0000;
      repeat (2) @(negedge clk);
      checks++;
      if (dir_ready !== 1'b0) begin
         errors++; $display("FAIL reset_dir_ready: got %b expected 0", dir_ready);
      end
      checks++;
      if (busy !== 1'b1) begin
         errors++; $display("FAIL reset_busy: got %b expected 1", busy);
      end
      checks++;
      if (game_over !== 1'b0 || game_won !== 1'b0) begin
         errors++; $display("FAIL reset_flags: got over=%b won=%b expected 0/0", game_over, game_won);
      end
      checks++;
      if (board !== '0 || score !== '0) begin
         errors++; $display("FAIL reset_clear: got board=%h score=%h expected 0", board, score);
      end
      rst = 1'b0;
      wait_ready(40, n, ok);
      checks++;
      if (!ok || n > 34) begin
         errors++; $display("FAIL reset_ready_latency: got %0d cycles (ok=%b) expected <=34", n, ok);
      end
      tiles   = 0;
      vals_ok = 1'b1;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (board[r][c] !== 12'd0) begin
               tiles++;
               if (board[r][c] !== 12'd2 && board[r][c] !== 12'd4) vals_ok = 1'b0;
            end
         end
      end
      checks++;
      if (tiles != 2 || !vals_ok) begin
         errors++; $display("FAIL reset_spawn: got %0d tiles vals_ok=%b expected 2 tiles of 2/4",
                            tiles, vals_ok);
      end
      checks++;
      if (score !== '0) begin
         errors++; $display("FAIL reset_score: got %h expected 0", score);
      end
   endtask

   task automatic test_move_up();
      board_t b, exp;
      int n, diffs;
      bit ok, spawn_ok;
      b    = '0;
      b[0] = mk_row(12'd2, 12'd2, 12'd4, 12'd4);
      b[1] = mk_row(12'd2, 12'd2, 12'd4, 12'd4);
      b[2] = mk_row(12'd0, 12'd0, 12'd4, 12'd0);
      b[3] = mk_row(12'd8, 12'd0, 12'd4, 12'd0);
      preload(b, '0);
      do_move(DIR_UP);
      wait_ready(40, n, ok);
      checks++;
      if (!ok) begin
         errors++; $display("FAIL up_timeout: got no dir_ready expected ready within 40");
      end
      // Column of four 4s merges into two 8s: 4+4+8+8+8 = 32 points.
      exp    = '0;
      exp[0] = mk_row(12'd4, 12'd4, 12'd8, 12'd8);
      exp[1] = mk_row(12'd8, 12'd0, 12'd8, 12'd0);
      diffs    = 0;
      spawn_ok = 1'b1;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (board[r][c] !== exp[r][c]) begin
               diffs++;
               if (exp[r][c] !== 12'd0 || (board[r][c] !== 12'd2 && board[r][c] !== 12'd4))
                  spawn_ok = 1'b0;
            end
         end
      end
      checks++;
      if (diffs != 1 || !spawn_ok) begin
         errors++; $display("FAIL up_board: got %h (diffs=%0d) expected %h plus one 2/4 tile",
                            board, diffs, exp);
      end
      checks++;
      if (score !== 20'd32) begin
         errors++; $display("FAIL up_score: got %0d expected 32", score);
      end
   endtask

   task automatic test_no_change();
      board_t b;
      b    = '0;
      b[0] = mk_row(12'd2, 12'd4, 12'd8, 12'd16);
      b[1] = mk_row(12'd4, 12'd0, 12'd0, 12'd0);
      preload(b, 20'd100);
      do_move(DIR_LEFT);
      checks++;
      if (dir_ready !== 1'b0 || busy !== 1'b1) begin
         errors++; $display("FAIL nochange_move_cycle: got ready=%b busy=%b expected 0/1",
                            dir_ready, busy);
      end
      @(negedge clk);
      checks++;
      if (dir_ready !== 1'b1) begin
         errors++; $display("FAIL nochange_latency: got ready=%b expected 1 two cycles after accept",
                            dir_ready);
      end
      checks++;
      if (board !== b || score !== 20'd100) begin
         errors++; $display("FAIL nochange_state: got board=%h score=%0d expected %h 100",
                            board, score, b);
      end
   endtask

   task automatic test_bad_dir();
      logic [3:0] bad [3] = '{4'b0011, 4'b0000, 4'b1111};
      board_t snap;
      score_t s;
      for (int i = 0; i < 3; i++) begin
         snap = board;
         s    = score;
         do_move(bad[i]);
         checks++;
         if (dir_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL baddir_ready_%0d: got ready=%b busy=%b expected 1/0",
                               i, dir_ready, busy);
         end
         @(negedge clk);
         checks++;
         if (board !== snap || score !== s || dir_ready !== 1'b1) begin
            errors++; $display("FAIL baddir_state_%0d: got board=%h score=%0d expected %h %0d",
                               i, board, score, snap, s);
         end
      end
   endtask

   task automatic test_saturate();
      board_t b;
      int n;
      bit ok;
      b    = '0;
      b[0] = mk_row(12'd2, 12'd2, 12'd0, 12'd0);
      preload(b, 20'hFFFFE);
      do_move(DIR_LEFT);
      wait_ready(40, n, ok);
      checks++;
      if (!ok || score !== 20'hFFFFF) begin
         errors++; $display("FAIL sat_score: got %h (ok=%b) expected fffff", score, ok);
      end
      checks++;
      if (board[0][0] !== 12'd4) begin
         errors++; $display("FAIL sat_tile: got %h expected 004", board[0][0]);
      end
   endtask

   task automatic test_start_wins();
      int n;
      bit ok;
      dir_valid = 1'b1;
      dir       = DIR_LEFT;
      start     = 1'b1;
      @(negedge clk);
      start     = 1'b0;
      dir_valid = 1'b0;
      dir       = 4'b0000;
      checks++;
      if (dut.state_q !== S_INIT || busy !== 1'b1) begin
         errors++; $display("FAIL startwins_state: got %s busy=%b expected S_INIT busy=1",
                            dut.state_q.name(), busy);
      end
      checks++;
      if (board !== '0 || score !== '0) begin
         errors++; $display("FAIL startwins_clear: got board=%h score=%h expected 0", board, score);
      end
      wait_ready(40, n, ok);
      checks++;
      if (!ok) begin
         errors++; $display("FAIL startwins_timeout: got no dir_ready expected ready within 40");
      end
   endtask

   task automatic test_win();
      board_t b;
      int n;
      bit ok;
      checks++;
      if (game_won !== 1'b0) begin
         errors++; $display("FAIL win_pre: got %b expected 0", game_won);
      end
      b    = '0;
      b[0] = mk_row(12'h400, 12'h400, 12'd0, 12'd0);
      preload(b, '0);
      do_move(DIR_LEFT);
      checks++;
      if (game_won !== 1'b0) begin
         errors++; $display("FAIL win_early: got %b expected 0 before S_CHECK", game_won);
      end
      wait_ready(40, n, ok);
      checks++;
      if (!ok || game_won !== 1'b1) begin
         errors++; $display("FAIL win_set: got won=%b (ok=%b) expected 1", game_won, ok);
      end
      checks++;
      if (score !== 20'h800 || board[0][0] !== 12'h800) begin
         errors++; $display("FAIL win_board: got score=%h tile=%h expected 800/800",
                            score, board[0][0]);
      end
      do_move(DIR_RIGHT);
      @(negedge clk);
      checks++;
      if (dut.state_q !== S_SPAWN) begin
         errors++; $display("FAIL win_in_spawn: got %s expected S_SPAWN", dut.state_q.name());
      end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (dut.state_q !== S_INIT || game_won !== 1'b0) begin
         errors++; $display("FAIL win_restart: got %s won=%b expected S_INIT won=0",
                            dut.state_q.name(), game_won);
      end
      checks++;
      if (board !== '0 || score !== '0) begin
         errors++; $display("FAIL win_restart_clear: got board=%h score=%h expected 0",
                            board, score);
      end
      wait_ready(40, n, ok);
      checks++;
      if (!ok) begin
         errors++; $display("FAIL win_restart_timeout: got no dir_ready expected ready within 40");
      end
   endtask

   task automatic test_game_over();
      board_t b, snap;
      int n;
      bit found, stayed;
      // Left leaves exactly one hole at row0 col3; neighbours 32 and 64 keep 2/4 unmatched.
      b    = '0;
      b[0] = mk_row(12'd8, 12'd0, 12'd16, 12'd32);
      b[1] = mk_row(12'd2, 12'd4, 12'd2,  12'd64);
      b[2] = mk_row(12'd4, 12'd2, 12'd4,  12'd2);
      b[3] = mk_row(12'd2, 12'd4, 12'd2,  12'd4);
      preload(b, '0);
      do_move(DIR_LEFT);
      n     = 0;
      found = 1'b0;
      while (n < 40 && !found) begin
         @(negedge clk);
         n++;
         if (game_over === 1'b1) found = 1'b1;
      end
      checks++;
      if (!found || dir_ready !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL over_reached: got over=%b ready=%b busy=%b expected 1/0/0",
                            game_over, dir_ready, busy);
      end
      checks++;
      if (board[0][0] !== 12'd8 || board[0][1] !== 12'd16 || board[0][2] !== 12'd32 ||
          (board[0][3] !== 12'd2 && board[0][3] !== 12'd4) || board[3:1] !== b[3:1]) begin
         errors++; $display("FAIL over_board: got %h expected row0 8,16,32,2|4 rest unchanged",
                            board);
      end
      snap      = board;
      stayed    = 1'b1;
      dir_valid = 1'b1;
      dir       = DIR_RIGHT;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (game_over !== 1'b1 || busy !== 1'b0 || dir_ready !== 1'b0) stayed = 1'b0;
      end
      dir_valid = 1'b0;
      dir       = 4'b0000;
      checks++;
      if (!stayed || board !== snap || score !== '0) begin
         errors++; $display("FAIL over_ignores_dir: got stayed=%b board=%h score=%h expected hold",
                            stayed, board, score);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_move_up();
      test_no_change();
      test_bad_dir();
      test_saturate();
      test_start_wins();
      test_win();
      test_game_over();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
